dram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 8x32 Debug RAM (DRAM) between the DMI (debugger) side and the core (hart debug-bus) side. It has one request/grant/response channel per requester and one access port driving the `sp_ram` byte-write interface. A round-robin pointer orders conflicting requests. Per-port response registers return read data with a one-cycle `rvalid` strobe.

---
 rtl/dm_dram_pkg.sv | 22 ++
 rtl/dram_port_rsp.sv | 40 ++++
 rtl/dram_arbiter.sv | 113 +++++++++++
 tb/tb_dram_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_dram_pkg.sv
// rtl/dm_dram_pkg.sv - shared types and constants for the Debug RAM arbiter
// Contents: DRAM geometry constants, port identifier enum, request payload struct.
package dm_dram_pkg;

    localparam int DRAM_AWIDTH    = 3;
    localparam int DRAM_NB_COL    = 4;
    localparam int DRAM_COL_WIDTH = 8;
    localparam int DRAM_DW        = DRAM_NB_COL * DRAM_COL_WIDTH;

    typedef enum logic {
        DRAM_PORT_DMI  = 1'b0,
        DRAM_PORT_CORE = 1'b1
    } dram_port_e;

    typedef struct packed {
        logic                      we;
        logic [DRAM_NB_COL-1:0]    be;
        logic [DRAM_AWIDTH-1:0]    addr;
        logic [DRAM_DW-1:0]        wdata;
    } dram_req_t;

endpackage

// File: rtl/dram_port_rsp.sv
// rtl/dram_port_rsp.sv - per-port response strobe and read-data capture register
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_gnt        port granted this cycle (already gated by reset)
//   i_we         granted access is a write
//   i_ram_dout   asynchronous RAM read data
//   o_rvalid     one-cycle strobe in the cycle after any grant
//   o_rdata      read data captured at the end of a read grant; held otherwise
module dram_port_rsp #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_gnt,
    input  logic          i_we,
    input  logic [DW-1:0] i_ram_dout,
    output logic          o_rvalid,
    output logic [DW-1:0] o_rdata
);

    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= i_gnt;
            // Writes return a strobe only; the last read value is kept.
            if (i_gnt && !i_we) begin
                r_rdata <= i_ram_dout;
            end
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin two-port arbiter onto the single-port Debug RAM
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   dmi_*  / core_*               request/grant/response channel per requester
//   ram_en, ram_we, ram_addr,
//   ram_din, ram_dout             byte-write single-port RAM access port
module dram_arbiter
    import dm_dram_pkg::*;
#(
    parameter int AWIDTH    = DRAM_AWIDTH,
    parameter int NB_COL    = DRAM_NB_COL,
    parameter int COL_WIDTH = DRAM_COL_WIDTH,
    parameter int DW        = NB_COL * COL_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              dmi_req,
    input  logic              dmi_we,
    input  logic [NB_COL-1:0] dmi_be,
    input  logic [AWIDTH-1:0] dmi_addr,
    input  logic [DW-1:0]     dmi_wdata,
    output logic              dmi_gnt,
    output logic              dmi_rvalid,
    output logic [DW-1:0]     dmi_rdata,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [NB_COL-1:0] core_be,
    input  logic [AWIDTH-1:0] core_addr,
    input  logic [DW-1:0]     core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DW-1:0]     core_rdata,

    output logic              ram_en,
    output logic [NB_COL-1:0] ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    dram_port_e r_last;
    dram_req_t  w_dmi_req;
    dram_req_t  w_core_req;
    dram_req_t  w_sel;
    logic       w_dmi_gnt;
    logic       w_core_gnt;
    logic       w_any_gnt;

    assign w_dmi_req  = '{we: dmi_we,  be: dmi_be,  addr: dmi_addr,  wdata: dmi_wdata};
    assign w_core_req = '{we: core_we, be: core_be, addr: core_addr, wdata: core_wdata};

    // Conflict goes to the port that was not granted last. Everything is
    // gated by rst_n so the RAM cannot be written while reset is asserted.
    always_comb begin
        w_dmi_gnt  = 1'b0;
        w_core_gnt = 1'b0;
        if (rst_n) begin
            if (dmi_req && core_req) begin
                if (r_last == DRAM_PORT_CORE) begin
                    w_dmi_gnt = 1'b1;
                end else begin
                    w_core_gnt = 1'b1;
                end
            end else begin
                w_dmi_gnt  = dmi_req;
                w_core_gnt = core_req;
            end
        end
    end

    assign w_any_gnt = w_dmi_gnt | w_core_gnt;
    assign w_sel     = w_core_gnt ? w_core_req : w_dmi_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= DRAM_PORT_CORE;
        end else if (w_dmi_gnt) begin
            r_last <= DRAM_PORT_DMI;
        end else if (w_core_gnt) begin
            r_last <= DRAM_PORT_CORE;
        end
    end

    assign dmi_gnt  = w_dmi_gnt;
    assign core_gnt = w_core_gnt;
    assign ram_en   = w_any_gnt;
    assign ram_we   = {NB_COL{w_any_gnt & w_sel.we}} & w_sel.be;
    assign ram_addr = w_sel.addr;
    assign ram_din  = w_sel.wdata;

    dram_port_rsp #(.DW(DW)) u_dmi_rsp (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_gnt      (w_dmi_gnt),
        .i_we       (dmi_we),
        .i_ram_dout (ram_dout),
        .o_rvalid   (dmi_rvalid),
        .o_rdata    (dmi_rdata)
    );

    dram_port_rsp #(.DW(DW)) u_core_rsp (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_gnt      (w_core_gnt),
        .i_we       (core_we),
        .i_ram_dout (ram_dout),
        .o_rvalid   (core_rvalid),
        .o_rdata    (core_rdata)
    );

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed scoreboard bench for dram_arbiter with a behavioural sp_ram
module tb_dram_arbiter;
    import dm_dram_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        dmi_req, dmi_we, dmi_gnt, dmi_rvalid;
    logic [3:0]  dmi_be;
    logic [2:0]  dmi_addr;
    logic [31:0] dmi_wdata, dmi_rdata;
    logic        core_req, core_we, core_gnt, core_rvalid;
    logic [3:0]  core_be;
    logic [2:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [2:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;

    dram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .dmi_req(dmi_req), .dmi_we(dmi_we), .dmi_be(dmi_be), .dmi_addr(dmi_addr),
        .dmi_wdata(dmi_wdata), .dmi_gnt(dmi_gnt), .dmi_rvalid(dmi_rvalid), .dmi_rdata(dmi_rdata),
        .core_req(core_req), .core_we(core_we), .core_be(core_be), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sp_ram: asynchronous read, byte-lane write on the rising edge.
    logic [31:0] ram_mem [8];
    assign ram_dout = ram_mem[ram_addr];
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (ram_we[l]) ram_mem[ram_addr][8*l +: 8] <= ram_din[8*l +: 8];
        end
    end

    typedef struct {
        dram_port_e  port;
        logic        is_read;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] exp_mem [8];
    dram_port_e  m_last;
    logic [31:0] m_rdata_dmi, m_rdata_core;
    int          n_assert, n_fail;
    int          n_rv_dmi, n_rv_core;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, check the combinational grant/RAM side,
    // push the predicted response, then advance past the clock edge.
    task automatic drive(input logic dr, input logic dw, input logic [3:0] dbe,
                         input logic [2:0] da, input logic [31:0] dd,
                         input logic cr, input logic cw, input logic [3:0] cbe,
                         input logic [2:0] ca, input logic [31:0] cd);
        logic       gd, gc, s_we;
        logic [3:0] s_be;
        logic [2:0] s_a;
        logic [31:0] s_d;
        rsp_t       e;
        dmi_req = dr;  dmi_we = dw;  dmi_be = dbe;  dmi_addr = da;  dmi_wdata = dd;
        core_req = cr; core_we = cw; core_be = cbe; core_addr = ca; core_wdata = cd;
        #1;
        gd = dr && (!cr || m_last == DRAM_PORT_CORE);
        gc = cr && (!dr || m_last == DRAM_PORT_DMI);
        check("dmi_gnt", dmi_gnt, gd);
        check("core_gnt", core_gnt, gc);
        check("ram_en", ram_en, gd | gc);
        s_we = gc ? cw : dw;  s_be = gc ? cbe : dbe;  s_a = gc ? ca : da;  s_d = gc ? cd : dd;
        check("ram_we", ram_we, (gd | gc) && s_we ? s_be : 4'b0);
        if (gd | gc) begin
            check("ram_addr", ram_addr, s_a);
            e.port    = gc ? DRAM_PORT_CORE : DRAM_PORT_DMI;
            e.is_read = !s_we;
            e.data    = exp_mem[s_a];
            if (s_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (s_be[l]) exp_mem[s_a][8*l +: 8] = s_d[8*l +: 8];
                end
            end
            sb.push_back(e);
            m_last = e.port;
        end
        @(posedge clk);
        #1;
        check_rsp();
    endtask

    task automatic check_rsp();
        logic ev_d, ev_c;
        rsp_t e;
        ev_d = 1'b0;
        ev_c = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == DRAM_PORT_DMI) begin
                ev_d = 1'b1;
                if (e.is_read) m_rdata_dmi = e.data;
            end else begin
                ev_c = 1'b1;
                if (e.is_read) m_rdata_core = e.data;
            end
        end
        check("dmi_rvalid", dmi_rvalid, ev_d);
        check("core_rvalid", core_rvalid, ev_c);
        check("dmi_rdata", dmi_rdata, m_rdata_dmi);
        check("core_rdata", core_rdata, m_rdata_core);
        if (dmi_rvalid) n_rv_dmi++;
        if (core_rvalid) n_rv_core++;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
    endtask

    task automatic model_reset();
        sb.delete();
        m_last       = DRAM_PORT_CORE;
        m_rdata_dmi  = 32'h0;
        m_rdata_core = 32'h0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 8; i++) begin
            ram_mem[i] = 32'h0;
            exp_mem[i] = 32'h0;
        end
        model_reset();

        // Reset with both ports requesting writes: nothing may reach the RAM.
        rst_n = 1'b0;
        dmi_req = 1'b1;  dmi_we = 1'b1;  dmi_be = 4'hF;  dmi_addr = 3'd1;  dmi_wdata = 32'hFFFF_FFFF;
        core_req = 1'b1; core_we = 1'b1; core_be = 4'hF; core_addr = 3'd1; core_wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dmi_gnt", dmi_gnt, 1'b0);
        check("rst_core_gnt", core_gnt, 1'b0);
        check("rst_ram_en", ram_en, 1'b0);
        check("rst_ram_we", ram_we, 4'h0);
        check("rst_dmi_rvalid", dmi_rvalid, 1'b0);
        check("rst_core_rvalid", core_rvalid, 1'b0);
        check("rst_dmi_rdata", dmi_rdata, 32'h0);
        check("rst_core_rdata", core_rdata, 32'h0);
        check("rst_no_ram_write", ram_mem[1], 32'h0);
        rst_n = 1'b1;

        // Contention from reset: DMI writes addr 5, core reads addr 5.
        n_rv_dmi  = 0;
        n_rv_core = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 4'hF, 3'd5, 32'h1234_5678,
                  1'b1, 1'b0, 4'h0, 3'd5, 32'h0);
            check("contention_order", {31'b0, m_last}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        check("contention_dmi_rvalid_count", n_rv_dmi, 32'd3);
        check("contention_core_rvalid_count", n_rv_core, 32'd3);
        check("contention_core_rdata", core_rdata, 32'h1234_5678);
        idle();

        // DMI full-word write then read-back on consecutive cycles.
        drive(1'b1, 1'b1, 4'hF, 3'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 3'd2, 32'h0,         1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        check("dmi_readback", dmi_rdata, 32'hDEAD_BEEF);
        idle();

        // Core single-byte write then read.
        drive(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 1'b1, 4'b0001, 3'd2, 32'h0000_00AA);
        drive(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 1'b0, 4'h0,    3'd2, 32'h0);
        check("core_byte_write", core_rdata, 32'hDEAD_BEAA);
        idle();

        // Zero byte-enable write: granted with a strobe but no RAM change.
        drive(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 1'b1, 4'h0, 3'd5, 32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 4'h0, 3'd5, 32'h0, 1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        check("be0_write_no_change", dmi_rdata, 32'h1234_5678);

        // Back-to-back DMI reads with the core idle; core write to the same
        // address as a later DMI read, granted in between.
        drive(1'b1, 1'b0, 4'h0, 3'd2, 32'h0, 1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 3'd7, 32'h0, 1'b1, 1'b1, 4'b1100, 3'd7, 32'hA5A5_0000);
        drive(1'b1, 1'b0, 4'h0, 3'd7, 32'h0, 1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
        check("dmi_sees_core_write", dmi_rdata, 32'hA5A5_0000);

        // Reset in the cycle after a DMI read grant.
        dmi_req = 1'b1; dmi_we = 1'b0; dmi_be = 4'h0; dmi_addr = 3'd2; dmi_wdata = 32'h0;
        core_req = 1'b0; core_we = 1'b0;
        #1;
        check("midrst_grant", dmi_gnt, 1'b1);
        @(posedge clk);
        #1;
        check("midrst_rvalid_pre", dmi_rvalid, 1'b1);
        dmi_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_dmi_rvalid", dmi_rvalid, 1'b0);
        check("midrst_dmi_rdata", dmi_rdata, 32'h0);
        check("midrst_core_rdata", core_rdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();

        // Normal arbitration immediately after release: DMI wins the conflict.
        drive(1'b1, 1'b0, 4'h0, 3'd5, 32'h0, 1'b1, 1'b0, 4'h0, 3'd2, 32'h0);
        drive(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 1'b0, 4'h0, 3'd2, 32'h0);
        check("post_rst_core_read", core_rdata, 32'hDEAD_BEAA);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
